snoop_initiator: RTL

SNOOP_INITIATOR -- requirements
Module: snoop_initiator

---
 rtl/ariane_ace_pkg.sv | 35 +++
 rtl/snoop_initiator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ariane_ace_pkg.sv
// Shared ACE snoop definitions: AC snoop type encodings, CR response bit
// positions, cache-line geometry and the snoop initiator FSM state type.
package ariane_ace;

   // Cache line geometry; the snoop data channel moves one line as LINE_BEATS beats.
   localparam int unsigned DCACHE_LINE_WIDTH = 128;
   localparam int unsigned CD_BEAT_WIDTH     = 64;
   localparam int unsigned LINE_BEATS        = DCACHE_LINE_WIDTH / CD_BEAT_WIDTH;

   // AC channel snoop types
   localparam logic [3:0] AC_READ_ONCE             = 4'b0000;
   localparam logic [3:0] AC_READ_SHARED           = 4'b0001;
   localparam logic [3:0] AC_READ_CLEAN            = 4'b0010;
   localparam logic [3:0] AC_READ_NOT_SHARED_DIRTY = 4'b0011;
   localparam logic [3:0] AC_READ_UNIQUE           = 4'b0111;
   localparam logic [3:0] AC_CLEAN_SHARED          = 4'b1000;
   localparam logic [3:0] AC_CLEAN_INVALID         = 4'b1001;
   localparam logic [3:0] AC_MAKE_INVALID          = 4'b1101;

   // CR channel response bit positions
   localparam int unsigned CR_DATA_TRANSFER = 0;
   localparam int unsigned CR_ERROR         = 1;
   localparam int unsigned CR_PASS_DIRTY    = 2;
   localparam int unsigned CR_IS_SHARED     = 3;
   localparam int unsigned CR_WAS_UNIQUE    = 4;

   typedef enum logic [2:0] {
      IDLE,
      SEND_AC,
      WAIT_CR,
      RECV_CD,
      RESP
   } snoop_state_e;

endpackage

// File: rtl/snoop_initiator.sv
// ACE snoop initiator: accepts one snoop request, issues it on AC, collects
// the CR response and (when DataTransfer is set) the CD line, then presents
// the result on the rsp channel.
// Optional CR/CD watchdog: define SNOOP_INITIATOR_TIMEOUT_EN.
module snoop_initiator
   import ariane_ace::*;
#(
   parameter int unsigned AddrWidth     = 64,
   parameter int unsigned DataWidth     = 64,
   parameter int unsigned LineBeats     = ariane_ace::LINE_BEATS,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   // request
   input  logic                           req_valid_i,
   output logic                           req_ready_o,
   input  logic [AddrWidth-1:0]           req_addr_i,
   input  logic [3:0]                     req_snoop_i,
   // snoop address channel
   output logic                           ac_valid_o,
   input  logic                           ac_ready_i,
   output logic [AddrWidth-1:0]           ac_addr_o,
   output logic [3:0]                     ac_snoop_o,
   output logic [2:0]                     ac_prot_o,
   // snoop response channel
   input  logic                           cr_valid_i,
   output logic                           cr_ready_o,
   input  logic [4:0]                     cr_resp_i,
   // snoop data channel
   input  logic                           cd_valid_i,
   output logic                           cd_ready_o,
   input  logic [DataWidth-1:0]           cd_data_i,
   input  logic                           cd_last_i,
   // response
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic [4:0]                     rsp_resp_o,
   output logic [LineBeats*DataWidth-1:0] rsp_data_o,
   output logic                           rsp_err_o
);

   localparam int unsigned LineWidth = LineBeats * DataWidth;
   localparam int unsigned LineBytes = LineWidth / 8;
   localparam int unsigned BeatWidth = (LineBeats > 1) ? $clog2(LineBeats) : 1;
   localparam logic [AddrWidth-1:0] LineMask = ~(AddrWidth'(LineBytes) - AddrWidth'(1));

   if ((LineBytes & (LineBytes - 1)) != 0) begin : g_bad_line
      $error("LineBeats*DataWidth/8 must be a power of two");
   end
   if (TimeoutCycles < 2) begin : g_bad_timeout
      $error("TimeoutCycles must be at least 2");
   end

   snoop_state_e           state_q, state_d;
   logic [AddrWidth-1:0]   addr_q;
   logic [3:0]             snoop_q;
   logic [4:0]             resp_q;
   logic [LineWidth-1:0]   data_q;
   logic                   err_q;
   logic [BeatWidth-1:0]   beat_q;
   logic                   last_beat;
   logic                   timer_hit;
   logic                   timeout;

   assign last_beat = (beat_q == BeatWidth'(LineBeats - 1));

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state and channel handshake outputs.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would infer a latch.
      state_d     = state_q;
      req_ready_o = 1'b0;
      ac_valid_o  = 1'b0;
      cr_ready_o  = 1'b0;
      cd_ready_o  = 1'b0;
      rsp_valid_o = 1'b0;
      timeout     = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) state_d = SEND_AC;
         end
         SEND_AC: begin
            ac_valid_o = 1'b1;
            if (ac_ready_i) state_d = WAIT_CR;
         end
         WAIT_CR: begin
            cr_ready_o = 1'b1;
            if (cr_valid_i) begin
               state_d = cr_resp_i[CR_DATA_TRANSFER] ? RECV_CD : RESP;
            end else if (timer_hit) begin
               timeout = 1'b1;
               state_d = RESP;
            end
         end
         RECV_CD: begin
            cd_ready_o = 1'b1;
            if (cd_valid_i) begin
               // an early last ends the line short; a missing last still ends it
               if (last_beat || cd_last_i) state_d = RESP;
            end else if (timer_hit) begin
               timeout = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request, response and line capture.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: the line buffer is reset because rsp_data_o must read zero out
      // of reset and for responses that carry no data.
      if (!rst_ni) begin
         addr_q  <= '0;
         snoop_q <= '0;
         resp_q  <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         beat_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  addr_q  <= req_addr_i & LineMask;
                  snoop_q <= req_snoop_i;
                  resp_q  <= '0;
                  data_q  <= '0;
                  err_q   <= 1'b0;
               end
            end
            WAIT_CR: begin
               if (cr_valid_i) begin
                  resp_q <= cr_resp_i;
                  err_q  <= cr_resp_i[CR_ERROR];
                  beat_q <= '0;
               end else if (timeout) begin
                  resp_q <= '0;
                  err_q  <= 1'b1;
               end
            end
            RECV_CD: begin
               if (cd_valid_i) begin
                  data_q[beat_q*DataWidth +: DataWidth] <= cd_data_i;
                  beat_q <= beat_q + BeatWidth'(1);
                  // last must coincide exactly with the final beat of the line
                  if (last_beat ^ cd_last_i) err_q <= 1'b1;
               end else if (timeout) begin
                  resp_q <= '0;
                  err_q  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SNOOP_INITIATOR_TIMEOUT_EN
   localparam int unsigned TimerWidth = $clog2(TimeoutCycles);
   logic [TimerWidth-1:0] timer_q;

   assign timer_hit = ((state_q == WAIT_CR) || (state_q == RECV_CD)) &&
                      (timer_q == TimerWidth'(TimeoutCycles - 1));

   // Watchdog: restarts on every state change, counts while waiting on CR/CD.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                           timer_q <= '0;
      else if (state_d != state_q)                           timer_q <= '0;
      else if ((state_q == WAIT_CR) || (state_q == RECV_CD)) timer_q <= timer_q + TimerWidth'(1);
   end
`else
   assign timer_hit = 1'b0;
`endif

   assign ac_addr_o  = addr_q;
   assign ac_snoop_o = snoop_q;
   assign ac_prot_o  = 3'b000;
   assign rsp_resp_o = resp_q;
   assign rsp_data_o = data_q;
   assign rsp_err_o  = err_q;

endmodule
